// File: rtl/gals_multi_source_ctrl_pkg.sv
// Shared types and constants for the multi-source GALS producer/consumer controller.
package gals_multi_source_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COMM  = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    localparam logic [3:0] LED_IDLE  = 4'b0001;
    localparam logic [3:0] LED_COMM  = 4'b0010;
    localparam logic [3:0] LED_WAIT  = 4'b0100;
    localparam logic [3:0] LED_DRAIN = 4'b1000;

    // Bits needed to index v items (v >= 2).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gals_multi_source_ctrl_if.sv
// Producer-side and wrapper-side handshake bundle of the GALS controller.
interface gals_multi_source_ctrl_if #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned DW    = 16
);
    logic [N_SRC-1:0]    src_en;
    logic [N_SRC-1:0]    src_valid;
    logic [N_SRC*DW-1:0] src_data;
    logic [DW-1:0]       data_1;
    logic                data_1_en;
    logic                buffer_full;
    logic                buffer_empty;
    logic                data_2_valid;

    modport master (
        output src_en, data_1, data_1_en,
        input  src_valid, src_data, buffer_full, buffer_empty, data_2_valid
    );

    modport slave (
        input  src_en, data_1, data_1_en,
        output src_valid, src_data, buffer_full, buffer_empty, data_2_valid
    );
endinterface

// File: rtl/gals_multi_source_ctrl_prio_enc.sv
// Lowest-set-bit priority encoder for the start request vector.
module prio_enc #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan from the top down so the lowest set bit is the last to write idx.
    always_comb begin
        idx = '0;
        any = |req;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[N-1-i]) idx = W'(N-1-i);
        end
    end

endmodule

// File: rtl/gals_multi_source_ctrl.sv
// Session controller: picks one producer, forwards its words to the dual-clock
// buffer wrapper, throttles on full, auto-stops on quota and drains on stop.
module gals_multi_source_ctrl
    import gals_multi_source_ctrl_pkg::*;
#(
    parameter int unsigned N_SRC     = 4,
    parameter int unsigned DW        = 16,
    parameter int unsigned MAX_WORDS = 0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_SRC-1:0]        start,
    input  logic                    stop,
    gals_multi_source_ctrl_if.master bus,
    output logic [3:0]              module_sig,
    output logic [3:0]              led,
    output logic [CNT_W-1:0]        words_sent
);

    localparam int unsigned SEL_W = clog2(N_SRC);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] words_sent_q, words_sent_d;

    logic [SEL_W-1:0] start_idx;
    logic             start_any;
    logic [DW-1:0]    sel_word;
    logic             sel_valid;
    logic             accept;
    logic [CNT_W-1:0] cnt_inc;
    logic             quota_hit;

    prio_enc #(
        .N (N_SRC),
        .W (SEL_W)
    ) u_prio_enc (
        .req (start),
        .idx (start_idx),
        .any (start_any)
    );

    assign sel_word  = bus.src_data[sel_q*DW +: DW];
    assign sel_valid = bus.src_valid[sel_q];
    assign accept    = (state_q == S_COMM) && sel_valid && !bus.buffer_full;
    assign cnt_inc   = (words_sent_q == '1) ? words_sent_q : words_sent_q + CNT_W'(1);
    assign quota_hit = (MAX_WORDS != 0) && accept && (cnt_inc == CNT_W'(MAX_WORDS));

    // State, selected source and word counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sel_q        <= '0;
            words_sent_q <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            words_sent_q <= words_sent_d;
        end
    end

    // Next-state, source latch and counter update.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        words_sent_d = words_sent_q;
        case (state_q)
            S_IDLE: begin
                if (start_any) begin
                    state_d      = S_COMM;
                    sel_d        = start_idx;
                    words_sent_d = '0;
                end
            end
            S_COMM: begin
                if (accept) words_sent_d = cnt_inc;
                if (stop)                 state_d = S_DRAIN;
                else if (quota_hit)       state_d = S_DRAIN;
                else if (bus.buffer_full) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (stop)                 state_d = S_DRAIN;
                else if (!bus.buffer_full) state_d = S_COMM;
            end
            S_DRAIN: begin
                if (bus.buffer_empty && !bus.data_2_valid) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                sel_d   = '0;
            end
        endcase
    end

    // Output decode from registered state; the write strobe also gates on live valid/full.
    always_comb begin
        bus.src_en    = '0;
        bus.data_1    = '0;
        bus.data_1_en = 1'b0;
        module_sig    = 4'b0000;
        led           = LED_IDLE;
        words_sent    = words_sent_q;
        case (state_q)
            S_COMM: begin
                bus.src_en[sel_q] = 1'b1;
                bus.data_1        = sel_word;
                bus.data_1_en     = accept;
                module_sig        = {1'b1, 3'(sel_q)};
                led               = LED_COMM;
            end
            S_WAIT: begin
                bus.data_1 = sel_word;
                module_sig = {1'b1, 3'(sel_q)};
                led        = LED_WAIT;
            end
            S_DRAIN: begin
                led = LED_DRAIN;
            end
            default: begin
                led = LED_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gals_multi_source_ctrl.sv
// Bench for gals_multi_source_ctrl: two instances share stimulus, one with an
// 8-word quota and one unlimited with a 3-bit saturating counter.
module tb_gals_multi_source_ctrl;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    start = '0;
    logic          stop  = 1'b0;
    logic [3:0]    v_valid = '0;
    logic [63:0]   v_data  = '0;
    logic          v_full  = 1'b0;
    logic          v_empty = 1'b1;
    logic          v_d2v   = 1'b0;
    int            tick = 0;

    logic [3:0]    ms_a, led_a, ms_b, led_b;
    logic [15:0]   ws_a;
    logic [2:0]    ws_b;

    int            n_chk  = 0;
    int            n_fail = 0;

    gals_multi_source_ctrl_if #(.N_SRC(4), .DW(16)) bus_a ();
    gals_multi_source_ctrl_if #(.N_SRC(4), .DW(16)) bus_b ();

    assign bus_a.src_valid    = v_valid;
    assign bus_a.src_data     = v_data;
    assign bus_a.buffer_full  = v_full;
    assign bus_a.buffer_empty = v_empty;
    assign bus_a.data_2_valid = v_d2v;
    assign bus_b.src_valid    = v_valid;
    assign bus_b.src_data     = v_data;
    assign bus_b.buffer_full  = v_full;
    assign bus_b.buffer_empty = v_empty;
    assign bus_b.data_2_valid = v_d2v;

    gals_multi_source_ctrl #(.N_SRC(4), .DW(16), .MAX_WORDS(8), .CNT_W(16)) dut_a (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .bus        (bus_a),
        .module_sig (ms_a),
        .led        (led_a),
        .words_sent (ws_a)
    );

    gals_multi_source_ctrl #(.N_SRC(4), .DW(16), .MAX_WORDS(0), .CNT_W(3)) dut_b (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .bus        (bus_b),
        .module_sig (ms_b),
        .led        (led_b),
        .words_sent (ws_b)
    );

    always #5 clock = ~clock;

    // Behavioural model: phase 0 idle, 1 forwarding, 2 waiting, 3 draining.
    int m_ph  [2] = '{0, 0};
    int m_sel [2] = '{0, 0};
    int m_cnt [2] = '{0, 0};
    int quota [2] = '{8, 0};
    int cmax  [2] = '{65535, 7};

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                m_ph[d] = 0; m_sel[d] = 0; m_cnt[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                bit took;
                took = (m_ph[d] == 1) && v_valid[m_sel[d]] && !v_full;
                if (m_ph[d] == 0) begin
                    if (start != 0) begin
                        for (int i = 3; i >= 0; i--) if (start[i]) m_sel[d] = i;
                        m_cnt[d] = 0;
                        m_ph[d]  = 1;
                    end
                end else if (m_ph[d] == 1) begin
                    if (took && m_cnt[d] < cmax[d]) m_cnt[d] = m_cnt[d] + 1;
                    if (stop) m_ph[d] = 3;
                    else if (quota[d] != 0 && took && m_cnt[d] == quota[d]) m_ph[d] = 3;
                    else if (v_full) m_ph[d] = 2;
                end else if (m_ph[d] == 2) begin
                    if (stop) m_ph[d] = 3;
                    else if (!v_full) m_ph[d] = 1;
                end else begin
                    if (v_empty && !v_d2v) m_ph[d] = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        #3;
        for (int d = 0; d < 2; d++) begin
            logic [31:0] e_en, e_d1, e_we, e_ms, e_led;
            bit on;
            on    = (m_ph[d] == 1) || (m_ph[d] == 2);
            e_en  = (m_ph[d] == 1) ? (32'd1 << m_sel[d]) : 32'd0;
            e_d1  = on ? 32'(v_data[m_sel[d]*16 +: 16]) : 32'd0;
            e_we  = ((m_ph[d] == 1) && v_valid[m_sel[d]] && !v_full) ? 32'd1 : 32'd0;
            e_ms  = on ? 32'(8 + m_sel[d]) : 32'd0;
            e_led = 32'd1 << m_ph[d];
            if (d == 0) begin
                chk("a.src_en", 32'(bus_a.src_en), e_en);
                chk("a.data_1", 32'(bus_a.data_1), e_d1);
                chk("a.data_1_en", 32'(bus_a.data_1_en), e_we);
                chk("a.module_sig", 32'(ms_a), e_ms);
                chk("a.led", 32'(led_a), e_led);
                chk("a.words_sent", 32'(ws_a), 32'(m_cnt[0]));
            end else begin
                chk("b.src_en", 32'(bus_b.src_en), e_en);
                chk("b.data_1", 32'(bus_b.data_1), e_d1);
                chk("b.data_1_en", 32'(bus_b.data_1_en), e_we);
                chk("b.module_sig", 32'(ms_b), e_ms);
                chk("b.led", 32'(led_b), e_led);
                chk("b.words_sent", 32'(ws_b), 32'(m_cnt[1]));
            end
        end
    end

    // Apply one cycle of inputs at a falling edge and return at the next one.
    task automatic cyc(input logic [3:0] st_i, input logic sp, input logic [3:0] vl,
                       input logic fu, input logic em, input logic dv);
        start   = st_i;
        stop    = sp;
        v_valid = vl;
        v_full  = fu;
        v_empty = em;
        v_d2v   = dv;
        tick++;
        for (int i = 0; i < 4; i++) v_data[i*16 +: 16] = 16'(i * 4096 + tick);
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("reset.led", 32'(led_a), 32'h1);
        chk("reset.words_sent", 32'(ws_a), 32'h0);
        chk("reset.module_sig", 32'(ms_a), 32'h0);

        // 1: single start on source 2, continuous valid
        cyc(4'b0100, 0, 4'b0100, 0, 1, 0);
        chk("t1.src_en", 32'(bus_a.src_en), 32'h4);
        chk("t1.module_sig", 32'(ms_a), 32'ha);
        chk("t1.data_1_en", 32'(bus_a.data_1_en), 32'h1);
        repeat (3) cyc(4'b0000, 0, 4'b0100, 0, 1, 0);
        cyc(4'b0000, 1, 4'b0000, 0, 1, 0);
        chk("t1.words_sent", 32'(ws_a), 32'd3);
        chk("t1.drain_led", 32'(led_a), 32'h8);
        cyc(4'b0000, 0, 4'b0000, 0, 1, 0);
        chk("t1.idle_led", 32'(led_a), 32'h1);

        // 2: simultaneous starts, lowest index wins
        cyc(4'b1010, 0, 4'b1111, 0, 1, 0);
        chk("t2.module_sig", 32'(ms_a), 32'h9);
        repeat (2) cyc(4'b0000, 0, 4'b1111, 0, 1, 0);

        // 3: buffer full for five cycles
        repeat (5) cyc(4'b0000, 0, 4'b1111, 1, 1, 0);
        chk("t3.wait_led", 32'(led_a), 32'h4);
        chk("t3.words_frozen", 32'(ws_a), 32'd2);
        chk("t3.no_write", 32'(bus_a.data_1_en), 32'h0);
        cyc(4'b0000, 0, 4'b1111, 0, 1, 0);
        chk("t3.resume_led", 32'(led_a), 32'h2);

        // 4: run until the quota of 8 forces a drain
        for (int k = 0; k < 20 && led_a != 4'b1000; k++) cyc(4'b0000, 0, 4'b1111, 0, 0, 0);
        chk("t4.drain_reached", 32'(led_a), 32'h8);
        chk("t4.words_sent", 32'(ws_a), 32'd8);
        chk("t4.b_saturated", 32'(ws_b), 32'd7);
        repeat (3) cyc(4'b0000, 0, 4'b0000, 0, 0, 0);
        chk("t4.drain_hold", 32'(led_a), 32'h8);
        cyc(4'b0000, 0, 4'b0000, 0, 1, 1);
        chk("t4.d2v_hold", 32'(led_a), 32'h8);
        cyc(4'b0000, 0, 4'b0000, 0, 1, 0);
        chk("t4.idle_led", 32'(led_a), 32'h1);

        // 5: stop with a non-empty buffer, start ignored while draining
        cyc(4'b0001, 0, 4'b0001, 0, 0, 0);
        cyc(4'b0000, 0, 4'b0001, 0, 0, 0);
        cyc(4'b0000, 1, 4'b0000, 0, 0, 0);
        cyc(4'b0010, 0, 4'b0000, 0, 0, 0);
        chk("t5.drain_led", 32'(led_a), 32'h8);
        chk("t5.module_sig", 32'(ms_a), 32'h0);
        chk("t5.src_en", 32'(bus_a.src_en), 32'h0);
        repeat (2) cyc(4'b0000, 0, 4'b0000, 0, 0, 0);
        cyc(4'b0000, 0, 4'b0000, 0, 1, 0);
        chk("t5.idle_led", 32'(led_a), 32'h1);

        // 6: asynchronous reset while waiting
        cyc(4'b0100, 0, 4'b0100, 0, 1, 0);
        cyc(4'b0000, 0, 4'b0100, 1, 1, 0);
        chk("t6.wait_led", 32'(led_a), 32'h4);
        #2 reset = 1'b1;
        #1;
        chk("t6.led", 32'(led_a), 32'h1);
        chk("t6.src_en", 32'(bus_a.src_en), 32'h0);
        chk("t6.data_1", 32'(bus_a.data_1), 32'h0);
        chk("t6.data_1_en", 32'(bus_a.data_1_en), 32'h0);
        chk("t6.module_sig", 32'(ms_a), 32'h0);
        chk("t6.b_led", 32'(led_b), 32'h1);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) cyc(4'b0000, 0, 4'b0000, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
